// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: round-robin owner of a two-line text LCD driver shared by N_REQ message sources.
// Latency: req seen in IDLE -> grant next cycle -> chars on line*_data the cycle after, held DWELL_CYC cycles.
// Backpressure: req is a level held until done; requests arriving while busy wait for the next IDLE cycle.
//
// Ports:
//   clk                  rising-edge system clock
//   rst                  asynchronous, active-low reset
//   req[N_REQ]           per-requester display request (level)
//   req_line1/2[8*N_REQ] per-requester chars, requester i at [8i+7:8i]
//   grant[N_REQ]         one-hot owner of the LCD (LOAD and SHOW)
//   done[N_REQ]          one-cycle pulse when an owner's dwell completes normally
//   line1_data/line2_data chars to the LCD driver (IDLE_CHAR when nothing is shown)
//   lcd_enable           LCD driver enable, high from the first edge after reset
//   busy                 high whenever the arbiter is not idle
//
// Optional feature macro: LCD_PRIO0_EN -- requester 0 becomes urgent: it wins every IDLE pick,
// preempts any other owner in SHOW, and serving it leaves the round-robin pointer untouched.

module lcd_msg_arbiter #(
    parameter int         N_REQ     = 4,
    parameter int         DWELL_CYC = 1000,
    parameter logic [7:0] IDLE_CHAR = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_line1,
    input  logic [8*N_REQ-1:0]   req_line2,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           line1_data,
    output logic [7:0]           line2_data,
    output logic                 lcd_enable,
    output logic                 busy
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DWELL_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [PTR_W:0]   N_WIDE   = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SHOW    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [PTR_W-1:0] rr_ptr;     // first requester examined in the next IDLE pick
    logic [PTR_W-1:0] w;          // current owner index
    logic [CNT_W-1:0] dwell_cnt;  // SHOW cycles already spent, minus one
    logic             adv_ptr;    // decided on leaving SHOW, applied in RELEASE

    // ------------------------------------------------------------------
    // Winner selection: first asserted req starting at rr_ptr, wrapping.
    // The scan runs from the farthest offset down to offset 0 so that the
    // nearest asserted requester is the last (and therefore kept) match.
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;
    logic [PTR_W:0]   scan_sum;
    logic [PTR_W-1:0] scan_idx;

    always_comb begin
        pick_idx = rr_ptr;
        pick_vld = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            // rr_ptr < N_REQ and k < N_REQ, so one conditional subtract wraps it
            scan_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan_sum >= N_WIDE) begin
                scan_sum = scan_sum - N_WIDE;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (req[scan_idx]) begin
                pick_idx = scan_idx;
                pick_vld = 1'b1;
            end
        end
`ifdef LCD_PRIO0_EN
        if (req[0]) begin
            pick_idx = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // SHOW exit conditions.
    // A dropped owner request takes precedence over normal completion, so
    // a requester that withdraws on its last dwell cycle gets no done.
    // ------------------------------------------------------------------
    logic owner_req;
    logic show_last;
    logic preempt;
    logic keep_ptr;
    logic show_exit;
    logic show_ok;

    assign owner_req = req[w];
    assign show_last = (dwell_cnt == CNT_LAST);

`ifdef LCD_PRIO0_EN
    // Requester 0 cuts in on anyone else; the preempted owner keeps its
    // place in the rotation (pointer untouched) unless it also withdrew.
    assign preempt  = req[0] && (w != '0);
    assign keep_ptr = (w == '0) || (owner_req && preempt);
`else
    assign preempt  = 1'b0;
    assign keep_ptr = 1'b0;
`endif

    assign show_exit = !owner_req || preempt || show_last;
    assign show_ok   = owner_req && !preempt && show_last;

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (show_exit) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Datapath: all outputs are registered so the LCD driver sees clean
    // levels; grant/data/done change on the state-transition edges.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            w          <= '0;
            dwell_cnt  <= '0;
            adv_ptr    <= 1'b0;
            grant      <= '0;
            done       <= '0;
            line1_data <= IDLE_CHAR;
            line2_data <= IDLE_CHAR;
            lcd_enable <= 1'b0;
        end else begin
            lcd_enable <= 1'b1;
            done       <= '0;
            case (state)
                S_IDLE: begin
                    dwell_cnt <= '0;
                    if (pick_vld) begin
                        w     <= pick_idx;
                        grant <= ONE_HOT0 << pick_idx;
                    end
                end
                S_LOAD: begin
                    // Chars are captured once here; later changes are ignored
                    line1_data <= req_line1[8*w +: 8];
                    line2_data <= req_line2[8*w +: 8];
                    dwell_cnt  <= '0;
                end
                S_SHOW: begin
                    if (show_exit) begin
                        grant      <= '0;
                        done       <= show_ok ? (ONE_HOT0 << w) : '0;
                        line1_data <= IDLE_CHAR;
                        line2_data <= IDLE_CHAR;
                        adv_ptr    <= !keep_ptr;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
                    dwell_cnt <= '0;
                    if (adv_ptr) begin
                        rr_ptr <= (w == PTR_MAX) ? '0 : w + 1'b1;
                    end
                end
                default: begin
                    dwell_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
module tb_lcd_msg_arbiter;

    localparam int         N  = 4;
    localparam int         D  = 8;
    localparam logic [7:0] IC = 8'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [31:0] req_line1 = 32'h0;
    logic [31:0] req_line2 = 32'h0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [7:0]  line1_data;
    logic [7:0]  line2_data;
    logic        lcd_enable;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    lcd_msg_arbiter #(
        .N_REQ    (N),
        .DWELL_CYC(D),
        .IDLE_CHAR(IC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_line1 (req_line1),
        .req_line2 (req_line2),
        .grant     (grant),
        .done      (done),
        .line1_data(line1_data),
        .line2_data(line2_data),
        .lcd_enable(lcd_enable),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a message "session" timeline. Age 0 is the grant
    // cycle, ages 1..m_end show the chars, age m_end+1 is the release cycle.
    // ------------------------------------------------------------------
    int         m_cur;      // owner, -1 when no session
    int         m_age;
    int         m_end;      // last showing age (D unless cut short)
    bit         m_norm;     // session ran its full dwell
    bit         m_keep;     // rotation pointer does not move for this session
    int         m_ptr;
    bit         m_en;
    logic [7:0] m_c1, m_c2;

    function automatic int pick_of(input logic [3:0] r, input int p);
        int idx;
`ifdef LCD_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int p;
        if (!rst) begin
            m_cur = -1; m_age = 0; m_end = D; m_norm = 0; m_keep = 0;
            m_ptr = 0; m_en = 0; m_c1 = IC; m_c2 = IC;
        end else begin
            m_en = 1;
            if (m_cur < 0) begin
                p = pick_of(req, m_ptr);
                if (p >= 0) begin
                    m_cur = p; m_age = 0; m_end = D; m_norm = 1; m_keep = 0;
`ifdef LCD_PRIO0_EN
                    if (p == 0) m_keep = 1;
`endif
                end
            end else if (m_age == 0) begin
                m_c1  = req_line1[8*m_cur +: 8];
                m_c2  = req_line2[8*m_cur +: 8];
                m_age = 1;
            end else if (m_age <= m_end) begin
                if (!req[m_cur]) begin
                    m_end = m_age; m_norm = 0;
                end
`ifdef LCD_PRIO0_EN
                else if (m_cur != 0 && req[0]) begin
                    m_end = m_age; m_norm = 0; m_keep = 1;
                end
`endif
                m_age++;
            end else begin
                if (!m_keep) m_ptr = (m_cur + 1) % N;
                m_cur = -1;
            end
        end
    end

    function automatic logic [25:0] m_expect();
        logic [3:0] g, d;
        logic [7:0] l1, l2;
        bit         show;
        g = 4'b0; d = 4'b0; l1 = IC; l2 = IC; show = 0;
        if (m_cur >= 0) begin
            if (m_age <= m_end) g = 4'b0001 << m_cur;
            if (m_age == m_end + 1 && m_norm) d = 4'b0001 << m_cur;
            show = (m_age >= 1 && m_age <= m_end);
        end
        if (show) begin l1 = m_c1; l2 = m_c2; end
        return {g, d, l1, l2, (m_cur >= 0), m_en};
    endfunction

    function automatic logic [24:0] pack(input logic [3:0] g, input logic [3:0] d,
                                         input logic [7:0] l1, input logic [7:0] l2, input logic b);
        return {g, d, l1, l2, b};
    endfunction

    // Bounded waits, each ending in one comparison (a timeout shows up as a mismatch)
    task automatic wait_grant(input string name, input logic [3:0] exp);
        int k = 0;
        while (grant == 4'b0 && k < 40) begin @(negedge clk); k++; end
        chk(name, grant, exp);
    endtask

    task automatic wait_done(input string name, input logic [3:0] exp);
        int k = 0;
        while (done == 4'b0 && k < 40) begin @(negedge clk); k++; end
        chk(name, done, exp);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin @(negedge clk); k++; end
        chk(name, busy, 1'b0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [24:0] exp;
    } vec_t;

    vec_t tv [12];

    initial begin
        int         rr_exp [5];
        int         last_cyc;
        logic [3:0] rr_req;

        // Single requester 2 on a quiet arbiter; chars change during SHOW
        // (rows 2..8) and must not reach the outputs.
        for (int i = 0; i < 12; i++) begin
            tv[i].req = (i <= 9) ? 4'b0100 : 4'b0000;
            tv[i].c1  = (i <= 1) ? 8'h41 : 8'h50 + 8'(i);
            tv[i].c2  = (i <= 1) ? 8'h42 : 8'h60 + 8'(i);
            if (i == 0)      tv[i].exp = pack(4'b0100, 4'b0000, IC, IC, 1'b1);
            else if (i <= 8) tv[i].exp = pack(4'b0100, 4'b0000, 8'h41, 8'h42, 1'b1);
            else if (i == 9) tv[i].exp = pack(4'b0000, 4'b0100, IC, IC, 1'b1);
            else             tv[i].exp = pack(4'b0000, 4'b0000, IC, IC, 1'b0);
        end

`ifdef LCD_PRIO0_EN
        rr_req = 4'b1110;
        rr_exp = '{1, 2, 3, 1, 2};
`else
        rr_req = 4'b1111;
        rr_exp = '{0, 1, 2, 3, 0};
`endif

        fork
            forever begin
                @(negedge clk);
                if (chk_en) chk("model", {grant, done, line1_data, line2_data, busy, lcd_enable}, m_expect());
            end
        join_none

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outs", {grant, done, line1_data, line2_data, busy}, pack(4'b0, 4'b0, IC, IC, 1'b0));
        chk("reset_en", lcd_enable, 1'b0);
        rst = 1'b1;
        #1 chk("en_before_edge", lcd_enable, 1'b0);
        @(negedge clk);
        chk("en_after_edge", lcd_enable, 1'b1);

        // ---------------- round-robin with all requests held ----------------
        req_line1 = 32'h44_43_42_41;
        req_line2 = 32'h64_63_62_61;
        req = rr_req;
        last_cyc = 0;
        for (int t = 0; t < 5; t++) begin
            wait_grant($sformatf("rr_grant%0d", t), 4'b0001 << rr_exp[t]);
            if (t > 0) chk($sformatf("rr_spacing%0d", t), 64'(cyc - last_cyc), 64'(D + 3));
            last_cyc = cyc;
            if (t == 4) begin
                req = 4'b0;
            end else begin
                wait_done($sformatf("rr_done%0d", t), 4'b0001 << rr_exp[t]);
                @(negedge clk);
                chk($sformatf("rr_done_pulse%0d", t), done, 4'b0);
            end
        end
        wait_idle("rr_idle");

        // ---------------- abort: requester 1 drops at SHOW cycle 3 ----------------
        req_line1[15:8] = 8'h31;
        req_line2[15:8] = 8'h32;
        req = 4'b0010;
        @(negedge clk);
        wait_grant("abort_grant", 4'b0010);
        repeat (3) @(negedge clk);
        chk("abort_show3", {grant, line1_data, line2_data}, {4'b0010, 8'h31, 8'h32});
        req = 4'b0;
        @(negedge clk);
        chk("abort_release", {grant, done, line1_data, line2_data, busy}, pack(4'b0, 4'b0, IC, IC, 1'b1));
        @(negedge clk);
        chk("abort_idle", {done, busy}, {4'b0, 1'b0});
        req = 4'b0110;  // next pick reveals rr_ptr: 2 expected after owner 1
        @(negedge clk);
        chk("abort_rr_ptr", grant, 4'b0100);
        wait_done("abort_next_done", 4'b0100);
        req = 4'b0;
        wait_idle("abort_next_idle");

        // ---------------- table-driven single-message vectors ----------------
        for (int i = 0; i < 12; i++) begin
            req = tv[i].req;
            req_line1[23:16] = tv[i].c1;
            req_line2[23:16] = tv[i].c2;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {grant, done, line1_data, line2_data, busy}, tv[i].exp);
        end

        // ---------------- requester 0 arriving during SHOW of 3 ----------------
        req = 4'b1000;
        wait_grant("p0_grant3", 4'b1000);
        repeat (2) @(negedge clk);
        req = 4'b1001;
`ifdef LCD_PRIO0_EN
        @(negedge clk);
        chk("p0_abort3", {grant, done}, 8'h00);
        repeat (2) @(negedge clk);
        chk("p0_grant0", grant, 4'b0001);
        wait_done("p0_done0", 4'b0001);
        req = 4'b1000;
        repeat (2) @(negedge clk);
        chk("p0_regrant3", grant, 4'b1000);
`else
        wait_done("p0_done3", 4'b1000);
        repeat (2) @(negedge clk);
        chk("p0_grant0", grant, 4'b0001);
`endif
        req = 4'b0;
        wait_idle("p0_idle");

        // ---------------- asynchronous reset in the middle of SHOW ----------------
        req = 4'b0001;
        wait_grant("rst_grant", 4'b0001);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_outs", {grant, done, line1_data, line2_data, busy}, pack(4'b0, 4'b0, IC, IC, 1'b0));
        chk("rst_mid_en", lcd_enable, 1'b0);
        req = 4'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 chk("rst_rel_en0", lcd_enable, 1'b0);
        @(posedge clk);
        #1 chk("rst_rel_en1", lcd_enable, 1'b1);
        @(negedge clk);

        // ---------------- randomized traffic against the model ----------------
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(7) == 0) begin
                        req[i] = 1'b1;
                        req_line1[8*i +: 8] = 8'($urandom);
                        req_line2[8*i +: 8] = 8'($urandom);
                    end
                end else if (done[i]) begin
                    if ($urandom_range(1) == 0) req[i] = 1'b0;
                end else if ($urandom_range(59) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(3) == 0) req_line1[8*i +: 8] = 8'($urandom);
            end
        end
        req = 4'b0;
        wait_idle("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
